// File: rtl/mx2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mx2_rr_arbiter
//   Packet-aware round-robin arbiter. NUM_REQ requesters share one registered
//   output channel. The winner's data is steered through a binary tree of 2:1
//   mux cells (NUM_REQ-1 cells per data bit). Each tree level is selected by
//   one bit of the grant index, and select bit 0 drives the leaf level. Once a
//   requester wins a word without last, it keeps the grant until it sends a
//   word with last=1.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]         per-requester valid
//   req_last   in   [NUM_REQ]         per-requester end-of-packet (with valid)
//   req_data   in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         one-hot (or zero) ready
//   out_valid  out  output register holds a word
//   out_data   out  [DATA_W] registered data
//   out_last   out  registered last flag
//   out_src    out  [IDX_W] requester that supplied out_data
//   out_ready  in   sink accepts the word
//   locked     out  a packet is in progress
// -----------------------------------------------------------------------------

// Two-input mux cell, one per tree node per data bit (maps onto CC_MX2).
module mx2_rr_arbiter_mx2 (
   input  logic d0,
   input  logic d1,
   input  logic s0,
   output logic y
);
   assign y = s0 ? d1 : d0;
endmodule

module mx2_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [IDX_W-1:0]          out_src,
   input  logic                      out_ready,
   output logic                      locked
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] own_q, own_d;

   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic             grant_hit;
   logic             load;
   logic             xfer;
   logic [DATA_W-1:0] mux_out;

   assign load   = !out_valid || out_ready;
   assign xfer   = grant_hit && load;
   assign locked = (state_q == LOCKED);

   // Candidate selection: the owner when locked, else the first valid index
   // at or after ptr. NUM_REQ is a power of two, so IDX_W-bit addition wraps.
   always_comb begin
      grant_idx = ptr_q;
      grant_hit = 1'b0;
      cand      = ptr_q;
      if (state_q == LOCKED) begin
         grant_idx = own_q;
         grant_hit = req_valid[own_q];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!grant_hit && req_valid[cand]) begin
               grant_idx = cand;
               grant_hit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_hit && load && !rst)
         req_ready[grant_idx] = 1'b1;
   end

   // Next-state: lock on a non-last word, release and rotate on a last word.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      if (xfer) begin
         if (req_last[grant_idx]) begin
            state_d = IDLE;
            ptr_d   = grant_idx + IDX_W'(1);
         end else begin
            state_d = LOCKED;
            own_d   = grant_idx;
         end
      end
   end

   // Mux tree: level 0 is the raw request words; level l+1 halves level l
   // using grant_idx[l]. The single word left at level IDX_W is the winner.
   for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
      logic [(NUM_REQ>>l)*DATA_W-1:0] v;
      if (l == 0) begin : g_leaf
         assign v = req_data;
      end else begin : g_node
         for (genvar j = 0; j < (NUM_REQ >> l); j++) begin : g_cell
            for (genvar b = 0; b < DATA_W; b++) begin : g_bit
               mx2_rr_arbiter_mx2 u_mx2 (
                  .d0 (g_lvl[l-1].v[(2*j)*DATA_W + b]),
                  .d1 (g_lvl[l-1].v[(2*j+1)*DATA_W + b]),
                  .s0 (grant_idx[l-1]),
                  .y  (v[j*DATA_W + b])
               );
            end
         end
      end
   end

   assign mux_out = g_lvl[IDX_W].v;

   // Output register stage and arbitration state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
         state_q   <= IDLE;
         ptr_q     <= '0;
         own_q     <= '0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= mux_out;
            out_last <= req_last[grant_idx];
            out_src  <= grant_idx;
         end
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
      end
   end

endmodule

// File: doc/mx2_rr_arbiter.md
Name: mx2_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between NUM_REQ requesters.
- The selected requester's data is steered onto the output through a binary tree of CC_MX2 cells, so the mux tree is NUM_REQ-1 CC_MX2 per data bit and the tree select comes from the grant index.
- Packet-aware: once a requester wins, the grant stays with it until it transfers a word with last=1.
- Sits in front of a single-consumer sink in GateMate verification designs to exercise CC_MX2 with sequenced, changing selects.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 2, data width per requester.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester ready; at most one bit set.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered data.
- out_last  output  1  registered last flag.
- out_src  output  IDX_W  index of the requester that supplied out_data.
- out_ready  input  1  sink accepts the word.
- locked  output  1  a packet is in progress.

Behaviour:
Reset (async on rst=1):
- out_valid=0, out_data=0, out_last=0, out_src=0, locked=0.
- Round-robin pointer ptr=0, lock owner own=0.
- req_ready=0 while rst=1.

Load enable:
- load = !out_valid || out_ready.
- The output stage is a single register with no skid buffer.

States:
- IDLE (locked=0): candidate g is the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- LOCKED (locked=1): candidate g=own, and only requester own is considered.

Ready:
- req_ready[g] = load && req_valid[g]. This is combinational and depends on out_ready.
- All other req_ready bits are 0.
- In LOCKED state with req_valid[own]=0, all req_ready=0 even if others are valid. There is no preemption.

Transfer (req_valid[g] && req_ready[g]) at the clock edge:
- out_data <= mux-tree output for index g; out_last <= req_last[g]; out_src <= g; out_valid <= 1.
- If req_last[g]=1: go to IDLE and set ptr <= (g+1) mod NUM_REQ.
- If req_last[g]=0: go to (or stay in) LOCKED with own <= g. ptr is unchanged.

Other cases:
- load=1 with no transfer: out_valid <= 0 and the data registers hold.
- load=0: all output registers, state, ptr and own hold. out_data must stay stable while out_valid && !out_ready.

Timing:
- Latency is 1 cycle from an accepted request to out_valid.
- Sustained throughput is one word per cycle when out_ready=1.

Boundary conditions:
- Single-word packets (last=1 on the first word) rotate the grant every word.
- Rotation to (g+1) mod NUM_REQ wraps from NUM_REQ-1 to 0.
- The round-robin search is purely combinational, with no extra cycle.
- If a requester drops req_valid mid-packet, the lock holds indefinitely until it returns.
- rst asserted mid-packet clears the lock and ptr immediately. The first grant after reset goes to the lowest valid index.

Select path:
- The tree select is g, driven bitwise into the CC_MX2 S0 inputs level by level.
- Select bit 0 drives the leaf level.

Test Plan:
- Reset: assert rst mid-transfer with req_valid=4'b1111 -> out_valid=0, locked=0, req_ready=0 during reset; after release with out_ready=1, the first grant is requester 0 (out_src=0).
- Round-robin: req_valid=4'b1111, req_last=4'b1111, data i=i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 and out_data equal to out_src, one cycle after each req_ready.
- Packet lock: requester 2 sends 3 words (last on the 3rd) while req_valid=4'b1111 -> out_src=2 for 3 consecutive words, locked=1 after words 1 and 2, then the next grant is requester 3.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data, out_src and out_last stable, req_ready=0; on release, the next word loads on the same edge the held word leaves.
- Sparse/wrap: only req_valid[3] and req_valid[1] set, ptr=2 -> grants 3 then 1 then 3; with no valid requests and out_ready=1 -> out_valid falls to 0 the next cycle.
- Stalled lock: lock on requester 1, drop req_valid[1] for 4 cycles with others valid -> no req_ready asserted, locked stays 1; resume with last=1 -> lock released and the grant moves to 2.
